// File: rtl/truthtable_sweep.sv
// Sweeps a 4-input combinational function through all 16 input codes, captures its
// truth table and compares it against EXPECTED, reporting mismatch count and first failure.
module truthtable_sweep #(
  parameter int unsigned SETTLE   = 0,
  parameter logic [15:0] EXPECTED = 16'hF080
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic [3:0]  dut_in_o,
  input  logic        dut_y_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] table_o,
  output logic [4:0]  mismatch_cnt_o,
  output logic [3:0]  fail_idx_o,
  output logic        pass_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [3:0] SettleLd = 4'(SETTLE);

  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  settle_q, settle_d;
  logic [15:0] table_q, table_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  fail_q, fail_d;
  logic        pass_q, pass_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    table_d  = table_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    pass_d   = pass_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d  = StRun;
          idx_d    = 4'd0;
          settle_d = SettleLd;
          table_d  = 16'h0000;
          cnt_d    = 5'd0;
          fail_d   = 4'd0;
          pass_d   = 1'b0;
        end
      end
      StRun: begin
        if (settle_q != 4'd0) begin
          settle_d = settle_q - 4'd1;
        end else begin
          table_d[idx_q] = dut_y_i;
          if (dut_y_i != EXPECTED[idx_q]) begin
            // A zero count means this is the first mismatch of the sweep.
            if (cnt_q == 5'd0) fail_d = idx_q;
            if (cnt_q != 5'd16) cnt_d = cnt_q + 5'd1;
          end
          settle_d = SettleLd;
          if (idx_q == 4'd15) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StDone: begin
        pass_d  = (cnt_q == 5'd0);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      idx_q    <= 4'd0;
      settle_q <= 4'd0;
      table_q  <= 16'h0000;
      cnt_q    <= 5'd0;
      fail_q   <= 4'd0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      table_q  <= table_d;
      cnt_q    <= cnt_d;
      fail_q   <= fail_d;
      pass_q   <= pass_d;
    end
  end

  assign busy_o         = (state_q == StRun);
  assign done_o         = (state_q == StDone);
  assign dut_in_o       = busy_o ? idx_q : 4'd0;
  assign table_o        = table_q;
  assign mismatch_cnt_o = cnt_q;
  assign fail_idx_o     = fail_q;
  assign pass_o         = pass_q;

endmodule

// File: tb/tb_truthtable_sweep.sv
// Scoreboard bench for truthtable_sweep: two instances (SETTLE 0 and 2) driving an emulated
// function under test; expected results are queued at start and popped when done pulses.
module tb_truthtable_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] tbl;
    logic [4:0]  cnt;
    logic [3:0]  fidx;
    logic        pas;
    int          dcyc;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // 0: y = b&(a|c&d), 1: stuck at 0, other: y = b
  function automatic logic [15:0] mk_lut(input int kind);
    logic [15:0] r;
    logic [3:0]  v;
    r = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      case (kind)
        0:       r[i] = v[2] & (v[3] | (v[1] & v[0]));
        1:       r[i] = 1'b0;
        default: r[i] = v[2];
      endcase
    end
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned S = (g == 0) ? 0 : 2;
    localparam int L = 16 * (S + 1);

    logic        rst_n, start, dut_y, busy, done, pass;
    logic [3:0]  dut_in, fail_idx;
    logic [15:0] tbl, lut;
    logic [4:0]  mcnt;

    int   sched[$];
    exp_t res[$];
    int   cur = -1;
    bit   pend = 1'b0;
    logic pexp;
    int   ndone = 0;
    bit   fin = 1'b0;

    assign dut_y = lut[dut_in];

    truthtable_sweep #(
      .SETTLE  (S),
      .EXPECTED(16'hF080)
    ) u_dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .start_i       (start),
      .dut_in_o      (dut_in),
      .dut_y_i       (dut_y),
      .busy_o        (busy),
      .done_o        (done),
      .table_o       (tbl),
      .mismatch_cnt_o(mcnt),
      .fail_idx_o    (fail_idx),
      .pass_o        (pass)
    );

    function automatic exp_t model(input logic [15:0] f, input int e0);
      exp_t e;
      logic [15:0] x;
      x      = f ^ 16'hF080;
      e.tbl  = f;
      e.cnt  = 5'($countones(x));
      e.fidx = 4'd0;
      for (int i = 15; i >= 0; i--) if (x[i]) e.fidx = 4'(i);
      e.pas  = (e.cnt == 5'd0);
      e.dcyc = e0 + L;
      return e;
    endfunction

    task automatic push(input logic [15:0] f, input int e0);
      sched.push_back(e0);
      res.push_back(model(f, e0));
    endtask

    task automatic wait_done(input int target);
      int n = 0;
      while (ndone < target && n < 3 * L + 10) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("inst%0d done_count", g), 32'(ndone), 32'(target));
    endtask

    task automatic sweep(input logic [15:0] f, input int pulse_at);
      int target = ndone + 1;
      lut = f;
      @(negedge clk);
      push(f, cyc + 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (pulse_at > 0) begin
        repeat (pulse_at - 1) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_done(target);
    endtask

    // Cycle-by-cycle stream check plus result scoreboard.
    always @(negedge clk) begin
      logic       eb, ed;
      logic [3:0] ei;
      exp_t       e;
      if (!rst_n) begin
        cur  = -1;
        pend = 1'b0;
        chk($sformatf("inst%0d reset_outputs", g),
            32'({dut_in, busy, done, tbl, mcnt, fail_idx, pass}), 32'd0);
      end else begin
        if (cur < 0 && sched.size() > 0 && sched[0] <= cyc) cur = sched.pop_front();
        eb = 1'b0; ed = 1'b0; ei = 4'd0;
        if (cur >= 0 && cyc - cur < L) begin
          eb = 1'b1;
          ei = 4'((cyc - cur) / (S + 1));
        end else if (cur >= 0 && cyc - cur == L) begin
          ed  = 1'b1;
          cur = -1;
        end
        chk($sformatf("inst%0d busy_done_dutin c%0d", g, cyc),
            32'({busy, done, dut_in}), 32'({eb, ed, ei}));
        if (pend) begin
          chk($sformatf("inst%0d pass", g), 32'(pass), 32'(pexp));
          pend = 1'b0;
        end
        if (done) begin
          if (res.size() == 0) begin
            chk($sformatf("inst%0d unexpected_done", g), 32'd1, 32'd0);
          end else begin
            e = res.pop_front();
            chk($sformatf("inst%0d table", g), 32'(tbl), 32'(e.tbl));
            chk($sformatf("inst%0d mismatch_cnt", g), 32'(mcnt), 32'(e.cnt));
            chk($sformatf("inst%0d fail_idx", g), 32'(fail_idx), 32'(e.fidx));
            chk($sformatf("inst%0d done_cycle", g), 32'(cyc), 32'(e.dcyc));
            pend = 1'b1;
            pexp = e.pas;
          end
          ndone++;
        end
      end
    end

    initial begin
      int          target, e0;
      logic [15:0] f1;
      rst_n = 1'b0;
      start = 1'b0;
      lut   = 16'h0000;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      sweep(mk_lut(0), 0);
      sweep(mk_lut(1), 0);
      sweep(mk_lut(2), 0);
      repeat (4) sweep(16'($urandom()), 0);
      sweep(16'hF080, 0);
      sweep(mk_lut(2), 5);

      // start held high across two sweeps
      target = ndone + 2;
      f1     = 16'($urandom());
      lut    = f1;
      @(negedge clk);
      e0 = cyc + 1;
      push(f1, e0);
      push(f1, e0 + L + 2);
      start = 1'b1;
      while (cyc < e0 + L + 2) @(negedge clk);
      start = 1'b0;
      wait_done(target);

      // reset in the middle of a sweep
      lut = mk_lut(1);
      @(negedge clk);
      push(lut, cyc + 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      #2 rst_n = 1'b0;
      sched.delete();
      res.delete();
      #1;
      chk($sformatf("inst%0d async_reset", g),
          32'({dut_in, busy, done, tbl, mcnt, fail_idx, pass}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      sweep(mk_lut(0), 0);
      sweep(16'($urandom()), 0);
      fin = 1'b1;
    end
  end

  initial begin
    while (!(g_inst[0].fin && g_inst[1].fin) && cyc < 20000) @(negedge clk);
    if (!(g_inst[0].fin && g_inst[1].fin)) chk("global_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
